// File: rtl/data_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_arbiter
// Description : Round-robin arbiter sharing one data-cache BRAM port, with a
//               latency-matched tag pipeline routing read data back to its issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ-1:0]            req_we_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  output logic                          bram_en_out,
  output logic                          bram_we_out,
  output logic [ADDR_WIDTH-1:0]         bram_addr_out,
  output logic [DATA_WIDTH-1:0]         bram_din_out,
  input  logic [DATA_WIDTH-1:0]         bram_dout_in
);

  localparam int c_ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_STAGES   = READ_LATENCY + 1;

  logic [c_ID_WIDTH-1:0] r_rr_ptr;
  logic [NUM_REQ-1:0]    w_upper;
  logic                  w_any;
  logic [c_ID_WIDTH-1:0] w_grant_id;
  logic [c_ID_WIDTH-1:0] w_next_ptr;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_hs;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NUM_REQ-1:0]    w_rsp_onehot;

  logic [c_STAGES-1:0]   r_tag_vld;
  logic [c_ID_WIDTH-1:0] r_tag_id [c_STAGES];

  // Requests at or above the pointer win first; otherwise wrap to the lowest valid index.
  always_comb begin
    w_upper    = '0;
    w_grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_upper[i] = req_valid_in[i] && (i >= int'(r_rr_ptr));
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_in[i]) w_grant_id = c_ID_WIDTH'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_upper[i]) w_grant_id = c_ID_WIDTH'(i);
    end
    w_any   = |req_valid_in;
    w_hs    = w_any && rst_in;
    w_grant = '0;
    if (w_hs) w_grant[w_grant_id] = 1'b1;
    if (w_grant_id == c_ID_WIDTH'(NUM_REQ - 1)) w_next_ptr = '0;
    else                                        w_next_ptr = w_grant_id + 1'b1;
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == c_ID_WIDTH'(i)) begin
        w_we    = req_we_in[i];
        w_addr  = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_onehot[i] = r_tag_vld[c_STAGES-1] && (r_tag_id[c_STAGES-1] == c_ID_WIDTH'(i));
    end
  end

  assign req_ready_out = w_grant;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rr_ptr      <= '0;
      bram_en_out   <= 1'b0;
      bram_we_out   <= 1'b0;
      bram_addr_out <= '0;
      bram_din_out  <= '0;
      rsp_valid_out <= '0;
      rsp_data_out  <= '0;
      r_tag_vld     <= '0;
      for (int s = 0; s < c_STAGES; s++) r_tag_id[s] <= '0;
    end else begin
      bram_en_out <= w_hs;
      bram_we_out <= w_hs && w_we;
      if (w_hs) begin
        r_rr_ptr      <= w_next_ptr;
        bram_addr_out <= w_addr;
        bram_din_out  <= w_wdata;
      end

      // Tag stage 0 aligns with the command register; the last stage aligns with dout.
      r_tag_vld[0] <= w_hs && !w_we;
      r_tag_id[0]  <= w_grant_id;
      for (int s = 1; s < c_STAGES; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end

      rsp_valid_out <= w_rsp_onehot;
      if (r_tag_vld[c_STAGES-1]) rsp_data_out <= bram_dout_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache_arbiter
// Description : Self-checking bench with a BRAM model and a transaction-level
//               reference model of the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LOGN = 8192;

  logic            clk_in = 1'b0;
  logic            rst_n  = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we    = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready_out;
  logic [N-1:0]    rsp_valid_out;
  logic [DW-1:0]   rsp_data_out;
  logic            bram_en_out;
  logic            bram_we_out;
  logic [AW-1:0]   bram_addr_out;
  logic [DW-1:0]   bram_din_out;
  logic [DW-1:0]   bram_dout;

  data_cache_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready_out), .req_we_in(req_we),
    .req_addr_in(req_addr), .req_wdata_in(req_wdata),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .bram_en_out(bram_en_out), .bram_we_out(bram_we_out), .bram_addr_out(bram_addr_out),
    .bram_din_out(bram_din_out), .bram_dout_in(bram_dout)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    if (a < 4) return DW'(16'hA0 + a);
    if (a >= 12'h100 && a < 12'h108) return DW'(16'hC000 + (a - 12'h100));
    return DW'(a * 7 + 3);
  endfunction

  // BRAM model: address registered in the command register, then two cycles to dout.
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] rd_q = '0;
  bit            init_done = 1'b0;
  always @(posedge clk_in) begin
    if (!init_done) begin
      for (int a = 0; a < 4096; a++) mem[a] <= init_word(a);
      init_done <= 1'b1;
    end else if (bram_en_out) begin
      if (bram_we_out) mem[bram_addr_out] <= bram_din_out;
      else             rd_q <= mem[bram_addr_out];
    end
    bram_dout <= rd_q;
  end

  // Reference model state
  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [DW-1:0] shadow [4096];
  int            m_ptr = 0;
  logic          m_en = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0, m_rd = '0;
  logic [N-1:0]  exp_g, exp_rv;
  logic [N-1:0]  last_hs = '0;
  int            cyc = 0;
  int            g, idx;
  bit            found;

  logic [N-1:0]  grant_log [LOGN];
  logic [N-1:0]  rv_log    [LOGN];
  logic [DW-1:0] rd_log    [LOGN];
  logic          en_log    [LOGN];

  always @(negedge clk_in) begin
    if (cyc < LOGN) begin
      grant_log[cyc] = req_ready_out;
      rv_log[cyc]    = rsp_valid_out;
      rd_log[cyc]    = rsp_data_out;
      en_log[cyc]    = bram_en_out;
    end
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready_out), 0);
      chk("rst_en", 32'(bram_en_out), 0);
      chk("rst_we", 32'(bram_we_out), 0);
      chk("rst_addr", 32'(bram_addr_out), 0);
      chk("rst_din", 32'(bram_din_out), 0);
      chk("rst_rsp_valid", 32'(rsp_valid_out), 0);
      chk("rst_rsp_data", 32'(rsp_data_out), 0);
      m_ptr = 0; m_en = 0; m_we = 0; m_addr = '0; m_din = '0; m_rd = '0;
      rq.delete();
      last_hs = '0;
      for (int a = 0; a < 4096; a++) shadow[a] = mem[a];
    end else begin
      found = 0; g = 0; exp_g = '0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid[idx]) begin found = 1; g = idx; end
      end
      if (found) exp_g[g] = 1'b1;
      chk("grant", 32'(req_ready_out), 32'(exp_g));
      chk("bram_en", 32'(bram_en_out), 32'(m_en));
      chk("bram_we", 32'(bram_we_out), 32'(m_we));
      chk("bram_addr", 32'(bram_addr_out), 32'(m_addr));
      chk("bram_din", 32'(bram_din_out), 32'(m_din));
      exp_rv = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rv[rq[0].id] = 1'b1;
        m_rd = rq[0].data;
        void'(rq.pop_front());
      end
      chk("rsp_valid", 32'(rsp_valid_out), 32'(exp_rv));
      chk("rsp_data", 32'(rsp_data_out), 32'(m_rd));
      if (found) begin
        m_ptr  = (g + 1) % N;
        m_en   = 1'b1;
        m_we   = req_we[g];
        m_addr = req_addr[g*AW +: AW];
        m_din  = req_wdata[g*DW +: DW];
        if (m_we) shadow[m_addr] = m_din;
        else      rq.push_back('{cyc + 4, g, shadow[m_addr]});
      end else begin
        m_en = 1'b0;
        m_we = 1'b0;
      end
      last_hs = req_valid & req_ready_out;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset(input int n);
    req_valid = '0;
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  int t0, t1, tr, tg, n0, n3;
  logic [N-1:0] acc;
  logic         acc_en;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Single write then read-after-write
    tick(); set_req(1, 1'b1, 12'h005, 16'h1234); t0 = cyc;
    tick(); req_valid = '0; set_req(2, 1'b0, 12'h005, 16'h0); t1 = cyc;
    tick(); req_valid = '0;
    repeat (8) tick();
    chk("t1_wr_grant", 32'(grant_log[t0]), 32'b0010);
    chk("t1_rd_grant", 32'(grant_log[t1]), 32'b0100);
    chk("t1_no_wr_rsp", 32'(rv_log[t0+4]), 0);
    chk("t1_rsp_valid", 32'(rv_log[t1+4]), 32'b0100);
    chk("t1_rsp_data", 32'(rd_log[t1+4]), 32'h1234);

    // Full contention
    do_reset(1);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
    t0 = cyc;
    repeat (N) begin tick(); req_valid &= ~last_hs; end
    repeat (8) tick();
    for (int k = 0; k < N; k++) begin
      chk("t2_grant", 32'(grant_log[t0+k]), 32'(1) << k);
      chk("t2_rsp_valid", 32'(rv_log[t0+4+k]), 32'(1) << k);
      chk("t2_rsp_data", 32'(rd_log[t0+4+k]), 32'h00A0 + 32'(k));
    end

    // Fairness between two continuous requesters
    do_reset(1);
    set_req(0, 1'b0, 12'h007, '0); set_req(3, 1'b0, 12'h008, '0); t0 = cyc;
    repeat (10) tick();
    req_valid = '0;
    repeat (8) tick();
    n0 = 0; n3 = 0;
    for (int k = 0; k < 10; k++) begin
      chk("t3_alternate", 32'(grant_log[t0+k]), (k % 2 == 1) ? 32'b1000 : 32'b0001);
      if (grant_log[t0+k] == 4'b0001) n0++;
      if (grant_log[t0+k] == 4'b1000) n3++;
    end
    chk("t3_count0", 32'(n0), 5);
    chk("t3_count3", 32'(n3), 5);

    // Back-to-back reads from one requester
    do_reset(1);
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin set_req(0, 1'b0, AW'(12'h100 + k), '0); tick(); end
    req_valid = '0;
    repeat (8) tick();
    for (int k = 0; k < 8; k++) begin
      chk("t4_grant", 32'(grant_log[t0+k]), 32'b0001);
      chk("t4_rsp_valid", 32'(rv_log[t0+4+k]), 32'b0001);
      chk("t4_rsp_data", 32'(rd_log[t0+4+k]), 32'hC000 + 32'(k));
    end

    // Reset with reads in flight
    do_reset(1);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin set_req(0, 1'b0, AW'(k), '0); tick(); end
    req_valid = '0;
    rst_n = 1'b0; t1 = cyc;
    tick(); rst_n = 1'b1;
    repeat (10) tick();
    acc = '0;
    for (int k = 0; k < 13; k++) acc |= rv_log[t0+k];
    chk("t5_no_rsp", 32'(acc), 0);
    chk("t5_rst_ready", 32'(grant_log[t1]), 0);
    chk("t5_rst_en", 32'(en_log[t1]), 0);
    chk("t5_rst_data", 32'(rd_log[t1]), 0);
    set_req(1, 1'b0, 12'h001, '0); tr = cyc;
    tick(); req_valid = '0;
    repeat (24) tick();

    // Idle keeps the pointer; next contention starts at requester 2
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
    tg = cyc;
    repeat (N) begin tick(); req_valid &= ~last_hs; end
    repeat (8) tick();
    chk("t5_rsp_valid", 32'(rv_log[tr+4]), 32'b0010);
    chk("t5_rsp_data", 32'(rd_log[tr+4]), 32'h00A1);
    acc = '0; acc_en = 1'b0;
    for (int k = 5; k < 25; k++) begin acc |= rv_log[tr+k]; acc_en |= en_log[tr+k]; end
    chk("t6_idle_rsp", 32'(acc), 0);
    chk("t6_idle_en", 32'(acc_en), 0);
    chk("t6_first_grant", 32'(grant_log[tg]), 32'b0100);
    chk("t6_second_grant", 32'(grant_log[tg+1]), 32'b1000);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      req_valid &= ~last_hs;
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 99) < 45)
            set_req(i, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 4095)) : AW'($urandom_range(0, 15)),
                    DW'($urandom));
        end
      end
    end
    req_valid = '0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_cache_arbiter.md
# data_cache_arbiter

Round-robin arbiter that shares the single port of the data-cache BRAM (DATA_CACHE_WIDTH × DATA_CACHE_DEPTH) among up to NUM_REQ requesters: the controller's LOAD path, processing cores and writeback. It accepts at most one read or write per cycle and drives registered BRAM command signals. It tracks in-flight reads through a latency-matched tag pipeline, so each read response returns to the requester that issued it.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, bits per data-cache word
- ADDR_WIDTH, 12, data-cache address bits (4096 words)
- READ_LATENCY, 2, BRAM cycles from registered address to valid dout (HIGH_PERFORMANCE mode)

Ports:
- clk_in  input  1  single clock; all logic on posedge
- rst_in  input  1  asynchronous, active-low reset
- req_valid_in  input  NUM_REQ  per-requester request valid
- req_ready_out  output  NUM_REQ  one-hot grant; handshake = valid & ready
- req_we_in  input  NUM_REQ  1 = write, 0 = read
- req_addr_in  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_in  input  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid_out  output  NUM_REQ  one-hot read-response strobe, 1 cycle
- rsp_data_out  output  DATA_WIDTH  shared read data, qualified by rsp_valid_out
- bram_en_out  output  1  BRAM port enable
- bram_we_out  output  1  BRAM write enable
- bram_addr_out  output  ADDR_WIDTH  BRAM address
- bram_din_out  output  DATA_WIDTH  BRAM write data
- bram_dout_in  input  DATA_WIDTH  BRAM read data

## Operation
- Arbitration is combinational within the cycle.
  - Among the asserted req_valid_in bits, grant the first index at or after rr_ptr, searching cyclically.
  - req_ready_out is one-hot for the winner and all-zero when no request is valid.
- On a handshake by requester g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - With no handshake, rr_ptr holds.
- Command register, loaded every cycle:
  - bram_en_out <= any handshake.
  - bram_we_out <= the winner's we.
  - bram_addr_out and bram_din_out <= the winner's fields.
  - With no handshake: en = we = 0 and addr/din hold their previous values.
- Tag pipeline: a shift register of depth READ_LATENCY+1. Each stage holds {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads valid = (handshake & ~we) and id = g.
  - The pipeline advances every cycle, with no stall.
- Response:
  - When the last stage is valid: rsp_data_out <= bram_dout_in and rsp_valid_out <= one-hot(id).
  - Otherwise rsp_valid_out <= 0 and rsp_data_out holds.
- Writes produce no response.
- Requester obligations:
  - Hold valid, we, addr and wdata stable until the handshake.
  - Always accept rsp_valid_out; there is no response backpressure.
- Read-after-write to the same address issued in consecutive cycles returns the new data, because the BRAM is write-before-read-ordered by issue order on one port.
- No state machine beyond rr_ptr; the tag pipeline forms the sequential datapath.

## Timing
- Reset (rst_in = 0, asynchronous assert, synchronous release):
  - rr_ptr = 0 and all tag stages are invalid.
  - bram_en_out = 0, bram_we_out = 0, bram_addr_out = 0, bram_din_out = 0.
  - rsp_valid_out = 0 and rsp_data_out = 0.
  - req_ready_out is forced to 0 while reset is asserted.
- Reset mid-operation discards all in-flight reads. No response is ever emitted for a request accepted before reset.
- Latency for a handshake in cycle T:
  - BRAM command is visible in cycle T+1.
  - bram_dout_in is valid in cycle T+1+READ_LATENCY.
  - rsp_valid_out and rsp_data_out are asserted in cycle T+2+READ_LATENCY (T+4 by default).
- Throughput is one accepted request per cycle, including back-to-back reads from the same requester.
- A single continuously requesting source gets a grant every cycle.
- Starvation bound: with all NUM_REQ requesters valid, each is granted exactly once every NUM_REQ cycles.
- Simultaneous events:
  - A new request issues in the same cycle a response retires; the two are independent.
  - Responses to one requester return in issue order.

## Test plan
- Single read: after reset, write 0x1234 to addr 0x005 via req 1, then read addr 0x005 via req 2 in the next cycle -> req_ready_out = 0b0100 on the read cycle; rsp_valid_out = 0b0100 and rsp_data_out = 0x1234 exactly 4 cycles later; no response for the write.
- Full contention: all 4 valid reading addresses 0..3 (preloaded 0xA0..0xA3), held until granted -> grants in order 0,1,2,3 on consecutive cycles; responses 0xA0..0xA3 on consecutive cycles starting 4 cycles after the first grant, each with the matching one-hot.
- Round-robin fairness: reqs 0 and 3 continuously valid for 10 cycles -> grants alternate 0,3,0,3…; each receives 5 grants.
- Pipelined throughput: req 0 reads addr 0x100..0x107 back-to-back -> 8 grants in 8 cycles; 8 consecutive rsp_valid_out = 0b0001 with data in address order.
- Reset mid-flight: issue 3 reads, then pull rst_in low for 1 cycle 2 cycles later -> rsp_valid_out stays 0 for 10 cycles; all outputs read 0 during reset; the next read after release returns correctly at T+4.
- Idle: no valid for 20 cycles -> bram_en_out = 0 and rsp_valid_out = 0 throughout; rr_ptr unchanged (the next grant order starts at the prior pointer).
